// File: rtl/wb_master_initiator_if.sv
// Command, response, Wishbone and status bundle for wb_master_initiator.
// master: the initiator side; slave: the command source / bus target side.
interface wb_master_initiator_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_we_i;
  logic [31:0]      cmd_adr_i;
  logic [31:0]      cmd_dat_i;
  logic [3:0]       cmd_sel_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_dat_o;
  logic             rsp_timeout_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;
  logic             busy_o;
  logic [CNT_W-1:0] txn_count_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i,
    input  cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o,
    output rsp_timeout_o, wbm_cyc_o, wbm_stb_o,
    output wbm_we_o, wbm_sel_o, wbm_adr_o,
    output wbm_dat_o, busy_o, txn_count_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i,
    output cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o,
    input  rsp_timeout_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_we_o, wbm_sel_o, wbm_adr_o,
    input  wbm_dat_o, busy_o, txn_count_o
  );
endinterface

// File: rtl/wb_master_initiator.sv
// Wishbone classic-cycle master: one command in, one bus cycle, one response out.
// Ports: wb_clk_i, wb_rst_i (sync active-low), bus (cmd/rsp/wishbone/status).
module wb_master_initiator #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_master_initiator_if.master bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TW-1:0]    timer_q;
  logic             cyc_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [31:0]      adr_q;
  logic [31:0]      wdat_q;
  logic [31:0]      rdat_q;
  logic             rsp_valid_q;
  logic             rsp_to_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo;
  logic             accept;
  logic             ack_done;
  logic             tmo_done;
  logic             rsp_done;

  // timer counts BUS cycles already completed before this edge
  assign tmo = (TIMEOUT != 0) && (timer_q == T_LAST);

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    ack_done        = 1'b0;
    tmo_done        = 1'b0;
    rsp_done        = 1'b0;
    bus.cmd_ready_o = 1'b0;
    bus.busy_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        bus.busy_o = 1'b1;
        // ack beats a coincident timeout
        if (bus.wbm_ack_i) begin
          ack_done = 1'b1;
          state_d  = RESP;
        end else if (tmo) begin
          tmo_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        bus.busy_o = 1'b1;
        if (bus.rsp_ready_i) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cyc_q   <= 1'b1;
        we_q    <= bus.cmd_we_i;
        sel_q   <= bus.cmd_sel_i;
        adr_q   <= bus.cmd_adr_i;
        wdat_q  <= bus.cmd_we_i ? bus.cmd_dat_i : '0;
        timer_q <= '0;
      end
      if (state_q == BUS) begin
        timer_q <= timer_q + TW'(1);
      end
      if (ack_done) begin
        cyc_q       <= 1'b0;
        rdat_q      <= we_q ? '0 : bus.wbm_dat_i;
        rsp_to_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        cnt_q       <= cnt_q + CNT_W'(1);
      end
      if (tmo_done) begin
        cyc_q       <= 1'b0;
        rdat_q      <= '0;
        rsp_to_q    <= 1'b1;
        rsp_valid_q <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wbm_cyc_o     = cyc_q;
  assign bus.wbm_stb_o     = cyc_q;
  assign bus.wbm_we_o      = we_q;
  assign bus.wbm_sel_o     = sel_q;
  assign bus.wbm_adr_o     = adr_q;
  assign bus.wbm_dat_o     = wdat_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_dat_o     = rdat_q;
  assign bus.rsp_timeout_o = rsp_to_q;
  assign bus.txn_count_o   = cnt_q;
endmodule
